// File: rtl/irq_pending_ctrl_pkg.sv
// Shared sizing constants and FSM state encoding for the interrupt pending controller.
package irq_pending_ctrl_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer per request line plus a history flop; reports one-cycle rising-edge events.
module irq_edge_sync
  import irq_pending_ctrl_pkg::*;
#(
  parameter int W = irq_pending_ctrl_pkg::NUM_REQ
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_req,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;

  // s1/s2 resolve metastability, s3 remembers the previous synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= async_req;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A line reads as a new event only for the cycle where the synchronized level is high and history is low.
  assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Latches request-line events, flags lost events, and offers the highest-priority unmasked line.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int NUM_REQ = irq_pending_ctrl_pkg::NUM_REQ,
  parameter int IDX_W   = irq_pending_ctrl_pkg::IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               ovr_clr,
  input  logic               pend_ack,
  output logic               pend_valid,
  output logic [IDX_W-1:0]   pend_idx,
  output logic [NUM_REQ-1:0] pending,
  output logic [NUM_REQ-1:0] overrun
);

  logic [NUM_REQ-1:0] evt;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] clr_vec;
  logic [NUM_REQ-1:0] ovr_set;
  state_t             state;
  state_t             state_nxt;
  logic               capture;
  logic               do_ack;

  // Highest set index wins; lower lines only matter when everything above them is clear.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [NUM_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  irq_edge_sync #(
    .W(NUM_REQ)
  ) u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .async_req(req_in),
    .rise     (evt)
  );

  // Masking only hides a line from the offer path; it never stops the event being latched.
  assign cand = pending & ~mask;

  // Overrun means a fresh event hit an already-pending bit that is not being consumed this edge.
  assign ovr_set = evt & pending & ~clr_vec;

  // Offer FSM: capture the winner on entry, hold it until the consumer accepts it.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    do_ack     = 1'b0;
    pend_valid = 1'b0;
    case (state)
      IDLE: begin
        if (|cand) begin
          state_nxt = OFFER;
          capture   = 1'b1;
        end
      end
      OFFER: begin
        pend_valid = 1'b1;
        if (pend_ack) begin
          state_nxt = IDLE;
          do_ack    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-hot clear for the bit being accepted this edge.
  always_comb begin
    clr_vec = '0;
    if (do_ack) clr_vec[pend_idx] = 1'b1;
  end

  // State and captured index; the index is frozen for the whole offer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pend_idx <= '0;
    end else begin
      state <= state_nxt;
      if (capture) pend_idx <= prio_enc(cand);
    end
  end

  // Event set beats ack clear, and a new overrun beats the global overrun clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | evt;
      overrun <= (ovr_clr ? '0 : overrun) | ovr_set;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scenario bench for irq_pending_ctrl with an offer scoreboard checked on every accepted offer.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic       ovr_clr;
  logic       pend_ack;
  logic       pend_valid;
  logic [1:0] pend_idx;
  logic [3:0] pending;
  logic [3:0] overrun;

  int total = 0;
  int bad   = 0;

  logic [1:0] sb[$];
  logic [1:0] exp_idx;

  irq_pending_ctrl #(
    .NUM_REQ(4),
    .IDX_W  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .ovr_clr   (ovr_clr),
    .pend_ack  (pend_ack),
    .pend_valid(pend_valid),
    .pend_idx  (pend_idx),
    .pending   (pending),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every offer that the bench accepts is compared against the next expected index.
  always @(negedge clk) begin
    if (!rst && pend_valid && pend_ack) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL offer_unexpected got idx=%0d required=no offer", pend_idx);
      end else begin
        exp_idx = sb.pop_front();
        if (pend_idx !== exp_idx) begin
          bad++;
          $display("[TB] FAIL offer_order got idx=%0d required=%0d", pend_idx, exp_idx);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n;
    n = 0;
    while (!pend_valid && n < budget) begin
      step(1);
      n++;
    end
    ok = pend_valid;
  endtask

  task automatic accept_one();
    pend_ack = 1'b1;
    step(1);
    pend_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = '0; mask = '0; ovr_clr = 1'b0; pend_ack = 1'b0;
    step(3);
    total++; if (pend_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b required=0", pend_valid); end
    total++; if (pend_idx !== 2'd0)   begin bad++; $display("[TB] FAIL rst_idx got=%0d required=0", pend_idx); end
    total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL rst_pending got=%b required=0000", pending); end
    total++; if (overrun !== 4'b0000) begin bad++; $display("[TB] FAIL rst_overrun got=%b required=0000", overrun); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_single();
    req_in = 4'b0100;
    step(2);
    total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL single_early got=%b required=0000", pending); end
    step(1);
    total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL single_latch got=%b required=0100", pending); end
    total++; if (pend_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_early got=%b required=0", pend_valid); end
    sb.push_back(2'd2);
    step(1);
    total++; if (pend_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b required=1", pend_valid); end
    total++; if (pend_idx !== 2'd2)   begin bad++; $display("[TB] FAIL single_idx got=%0d required=2", pend_idx); end
    accept_one();
    total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL single_cleared got=%b required=0000", pending); end
    total++; if (pend_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_after got=%b required=0", pend_valid); end
    req_in = '0;
    step(4);
    total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL single_sb got=%0d left required=0", sb.size()); end
  endtask

  task automatic test_priority();
    bit ok;
    req_in = 4'b1011;
    sb.push_back(2'd3); sb.push_back(2'd1); sb.push_back(2'd0);
    wait_valid(10, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL prio_first got=no offer required=offer"); end
    for (int i = 0; i < 3; i++) begin
      accept_one();
      total++; if (pend_valid !== 1'b0) begin bad++; $display("[TB] FAIL prio_gap%0d got=%b required=0", i, pend_valid); end
      if (i < 2) begin
        step(1);
        total++; if (pend_valid !== 1'b1) begin bad++; $display("[TB] FAIL prio_next%0d got=%b required=1", i, pend_valid); end
      end
    end
    total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL prio_end got=%b required=0000", pending); end
    req_in = '0;
    step(4);
    total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL prio_sb got=%0d left required=0", sb.size()); end
  endtask

  task automatic test_hold_offer();
    bit ok;
    req_in = 4'b0010;
    sb.push_back(2'd1); sb.push_back(2'd3);
    wait_valid(10, ok);
    total++; if (!ok || pend_idx !== 2'd1) begin bad++; $display("[TB] FAIL hold_first got valid=%b idx=%0d required valid=1 idx=1", pend_valid, pend_idx); end
    req_in = 4'b1010;
    step(4);
    total++; if (pending !== 4'b1010) begin bad++; $display("[TB] FAIL hold_pending got=%b required=1010", pending); end
    total++; if (pend_valid !== 1'b1 || pend_idx !== 2'd1) begin bad++; $display("[TB] FAIL hold_stable got valid=%b idx=%0d required valid=1 idx=1", pend_valid, pend_idx); end
    accept_one();
    wait_valid(5, ok);
    total++; if (!ok || pend_idx !== 2'd3) begin bad++; $display("[TB] FAIL hold_next got valid=%b idx=%0d required valid=1 idx=3", pend_valid, pend_idx); end
    accept_one();
    total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL hold_end got=%b required=0000", pending); end
    req_in = '0;
    step(4);
    total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL hold_sb got=%0d left required=0", sb.size()); end
  endtask

  task automatic test_mask();
    bit ok;
    mask = 4'b0001;
    req_in = 4'b0001;
    step(6);
    total++; if (pending !== 4'b0001) begin bad++; $display("[TB] FAIL mask_pending got=%b required=0001", pending); end
    total++; if (pend_valid !== 1'b0) begin bad++; $display("[TB] FAIL mask_blocked got=%b required=0", pend_valid); end
    pend_ack = 1'b1;
    step(2);
    pend_ack = 1'b0;
    total++; if (pending !== 4'b0001) begin bad++; $display("[TB] FAIL idle_ack got=%b required=0001", pending); end
    sb.push_back(2'd0);
    mask = 4'b0000;
    wait_valid(2, ok);
    total++; if (!ok || pend_idx !== 2'd0) begin bad++; $display("[TB] FAIL mask_release got valid=%b idx=%0d required valid=1 idx=0", pend_valid, pend_idx); end
    accept_one();
    req_in = '0;
    step(4);
    total++; if (pending !== 4'b0000 || sb.size() != 0) begin bad++; $display("[TB] FAIL mask_end got pending=%b left=%0d required pending=0000 left=0", pending, sb.size()); end
  endtask

  task automatic test_overrun();
    bit ok;
    sb.push_back(2'd2);
    req_in = 4'b0100; step(3);
    req_in = 4'b0000; step(3);
    req_in = 4'b0100; step(3);
    total++; if (overrun !== 4'b0100) begin bad++; $display("[TB] FAIL ovr_set got=%b required=0100", overrun); end
    total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL ovr_pending got=%b required=0100", pending); end
    total++; if (pend_valid !== 1'b1 || pend_idx !== 2'd2) begin bad++; $display("[TB] FAIL ovr_offer got valid=%b idx=%0d required valid=1 idx=2", pend_valid, pend_idx); end
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    total++; if (overrun !== 4'b0000) begin bad++; $display("[TB] FAIL ovr_clr got=%b required=0000", overrun); end
    req_in = 4'b0000; step(3);
    req_in = 4'b0100;
    step(2);
    accept_one();
    total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL ack_race_pending got=%b required=0100", pending); end
    total++; if (overrun !== 4'b0000) begin bad++; $display("[TB] FAIL ack_race_overrun got=%b required=0000", overrun); end
    sb.push_back(2'd2);
    wait_valid(5, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL ack_race_reoffer got=no offer required=offer"); end
    accept_one();
    total++; if (pending !== 4'b0000 || overrun !== 4'b0000) begin bad++; $display("[TB] FAIL ovr_end got pending=%b overrun=%b required 0000/0000", pending, overrun); end
    req_in = '0;
    step(4);
    total++; if (sb.size() != 0) begin bad++; $display("[TB] FAIL ovr_sb got=%0d left required=0", sb.size()); end
  endtask

  task automatic test_reset_offer();
    bit ok;
    int offers;
    req_in = 4'b1000;
    sb.push_back(2'd3);
    wait_valid(10, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL rstoff_offer got=no offer required=offer"); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (pend_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstoff_valid got=%b required=0", pend_valid); end
    total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL rstoff_pending got=%b required=0000", pending); end
    sb.delete();
    req_in = 4'b0001;
    step(2);
    rst = 1'b0;
    sb.push_back(2'd0);
    offers = 0;
    for (int i = 0; i < 20; i++) begin
      if (pend_valid) begin
        offers++;
        accept_one();
      end else begin
        step(1);
      end
    end
    total++; if (offers != 1) begin bad++; $display("[TB] FAIL rstoff_count got=%0d required=1", offers); end
    total++; if (pending !== 4'b0000 || sb.size() != 0) begin bad++; $display("[TB] FAIL rstoff_end got pending=%b left=%0d required 0000/0", pending, sb.size()); end
    req_in = '0;
    step(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_hold_offer();
    test_mask();
    test_overrun();
    test_reset_offer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout required=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
